arm_code_emitter: RTL
=====================

Name: arm_code_emitter

Overview:
- Sits directly downstream of the bytecode translator: consumes the 32-bit ARM instruction stream (push-immediate and decoded linked-list instructions) and writes it word-by-word into the ARM code memory.
- Decouples translator from code-memory stalls with a small FIFO.
- On flush, drains the FIFO, appends a return instruction (BX LR, 32'hE12FFF1E) and reports completion with the emitted word count.

Parameters:
- ADDRESS_WIDTH, 16, code-memory word-address width.
- FIFO_DEPTH, 8, instruction FIFO entries (power of two, >=2).
- TERM_INST, 32'hE12FFF1E, terminator word appended on flush.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: latch base_addr/code_limit, begin a method
- base_addr  in  ADDRESS_WIDTH  first code word address
- code_limit  in  ADDRESS_WIDTH  last writable word address (inclusive)
- arm_inst  in  32  translated ARM instruction
- inst_valid  in  1  arm_inst valid this cycle
- inst_ready  out  1  emitter accepts arm_inst this cycle
- flush  in  1  one-cycle pulse: method finished, drain and terminate
- cm_we  out  1  code-memory write request
- cm_addr  out  ADDRESS_WIDTH  write word address
- cm_wdata  out  32  write data
- cm_ack  in  1  memory accepted the write this cycle
- busy  out  1  not IDLE/DONE/ERR
- done  out  1  one-cycle pulse, terminator written
- error  out  1  sticky: code_limit overrun
- word_count  out  ADDRESS_WIDTH  words written since start (incl. terminator)

Behaviour:
- Reset (reset low, asynchronous): state IDLE, FIFO empty, inst_ready=0, cm_we=0, cm_addr=0, cm_wdata=0, busy=0, done=0, error=0, word_count=0.
- States: IDLE, RUN, DRAIN, TERM, DONE, ERR.
- IDLE/DONE/ERR + start -> RUN: cm_addr<=base_addr, limit latched, FIFO cleared, word_count<=0, error<=0. start in any other state ignored.
- RUN: inst_ready = !full. Push when inst_valid && inst_ready. flush -> DRAIN (a push in the flush cycle is still accepted). flush while FIFO empty and no push -> TERM directly.
- DRAIN: inst_ready=0; when FIFO empty and no write outstanding -> TERM.
- TERM: cm_wdata=TERM_INST; on cm_ack -> DONE, done=1 for exactly that following cycle, word_count+1.
- DONE: idle-equivalent; word_count and cm_addr held until next start.
- Write side (RUN, DRAIN): cm_we=1 whenever FIFO non-empty; cm_wdata=FIFO head, cm_addr=current address; both held stable while cm_we=1 and cm_ack=0. On cm_ack: pop, cm_addr+1, word_count+1; next entry may be presented the following cycle (max 1 word/cycle throughput). cm_ack with cm_we=0 ignored.
- Latency: instruction pushed in cycle N appears on cm_wdata/cm_we no earlier than N+1 (registered FIFO).
- Push and pop in same cycle: both occur, occupancy unchanged; inst_ready computed from current occupancy only (no combinational pass-through from cm_ack).
- Overrun: before asserting cm_we (data or terminator), if cm_addr > code_limit -> ERR: cm_we=0, inst_ready=0, error=1 sticky, FIFO contents discarded, done never pulses. Terminator needs its own slot: a method filling exactly to code_limit with data overruns on TERM.
- cm_addr wraps modulo 2^ADDRESS_WIDTH only if code_limit permits (no special handling).
- Full: inst_ready=0; translator must hold arm_inst/inst_valid.
- Reset mid-operation: all state aborted immediately, no further writes; partially written code is not cleaned up.

Test Plan:
- Reset low mid-write (cm_we=1) -> cm_we, busy, inst_ready drop asynchronously; all outputs at reset values.
- start base=16'h0100 limit=16'h01FF, push 32'hE3400005, 32'hE52D0004, flush, cm_ack always 1 -> writes 0x0100/E3400005, 0x0101/E52D0004, 0x0102/E12FFF1E; done one cycle; word_count=3.
- cm_ack held 0 while pushing 10 instructions, FIFO_DEPTH=8 -> inst_ready low after 8 accepted; cm_addr/cm_wdata stable; releasing ack drains all 10 in order, no loss/duplication.
- start, immediate flush with no pushes -> single write TERM_INST at base_addr, done, word_count=1.
- base=16'h0010 limit=16'h0011, push 2 instructions, flush -> two data writes, then ERR before terminator: error=1, done never asserts, word_count=2.
- Sustained valid with cm_ack=1 every cycle -> one word written per cycle, FIFO never fills; push and pop same cycle keep occupancy constant.

Source files
------------

// File: rtl/arm_code_emitter_if.sv
`default_nettype none
// ============================================================================
//  Module      : arm_code_emitter_if
//  Description : Instruction-stream and code-memory write bus between the
//                bytecode translator, the ARM code emitter and code memory.
//                The master modport is the emitter's view; the slave modport
//                is the view of its surroundings (translator and memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface arm_code_emitter_if #(
    parameter int ADDRESS_WIDTH = 16
);
    // Translator -> emitter instruction stream
    logic [31:0]              arm_inst;
    logic                     inst_valid;
    logic                     inst_ready;

    // Emitter -> code memory write port
    logic                     cm_we;
    logic [ADDRESS_WIDTH-1:0] cm_addr;
    logic [31:0]              cm_wdata;
    logic                     cm_ack;

    modport master (
        input  arm_inst,
        input  inst_valid,
        output inst_ready,
        output cm_we,
        output cm_addr,
        output cm_wdata,
        input  cm_ack
    );

    modport slave (
        output arm_inst,
        output inst_valid,
        input  inst_ready,
        input  cm_we,
        input  cm_addr,
        input  cm_wdata,
        output cm_ack
    );
endinterface
`default_nettype wire

// File: rtl/arm_code_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : arm_code_emitter
//  Description : Buffers translated ARM instructions in a small FIFO and
//                writes them word-by-word into code memory. On flush it
//                drains the FIFO, appends a return instruction and reports
//                completion; writing past code_limit aborts into a sticky
//                error state.
//  Revision    : 1.0 - initial release
// ============================================================================
module arm_code_emitter #(
    parameter int          ADDRESS_WIDTH = 16,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [31:0] TERM_INST     = 32'hE12FFF1E
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH-1:0] code_limit,
    input  logic                     flush,
    arm_code_emitter_if.master       bus,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH-1:0] word_count
);

    localparam int                   c_ptr_w    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                   c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]   c_depth    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]   c_ptr_one  = c_ptr_w'(1);
    localparam logic [ADDRESS_WIDTH-1:0] c_addr_one = ADDRESS_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_TERM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Registered state and outputs
    state_t                   state_q,      state_d;
    logic [c_ptr_w-1:0]       rd_ptr_q,     rd_ptr_d;
    logic [c_ptr_w-1:0]       wr_ptr_q,     wr_ptr_d;
    logic [c_cnt_w-1:0]       count_q,      count_d;
    logic [ADDRESS_WIDTH-1:0] limit_q,      limit_d;
    logic [ADDRESS_WIDTH-1:0] cm_addr_q,    cm_addr_d;
    logic [31:0]              cm_wdata_q,   cm_wdata_d;
    logic                     cm_we_q,      cm_we_d;
    logic                     inst_ready_q, inst_ready_d;
    logic                     busy_q,       busy_d;
    logic                     done_q,       done_d;
    logic                     error_q,      error_d;
    logic [ADDRESS_WIDTH-1:0] word_count_q, word_count_d;

    logic [31:0]              fifo_mem_q [FIFO_DEPTH];

    // Per-cycle decode
    state_t                   state_n;
    logic                     push;
    logic                     fire;
    logic                     pop;
    logic                     stay_empty;
    logic                     want_write;
    logic                     overrun;
    logic [c_ptr_w-1:0]       head_ptr;

    assign bus.inst_ready = inst_ready_q;
    assign bus.cm_we      = cm_we_q;
    assign bus.cm_addr    = cm_addr_q;
    assign bus.cm_wdata   = cm_wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = word_count_q;

    // Next-state, FIFO bookkeeping and next values of all registered outputs
    always_comb begin
        push         = bus.inst_valid && inst_ready_q;
        fire         = cm_we_q && bus.cm_ack;
        pop          = fire && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

        state_n      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        limit_d      = limit_q;
        cm_addr_d    = cm_addr_q;
        word_count_d = word_count_q;
        error_d      = error_q;
        done_d       = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + c_ptr_one;
            cm_addr_d = cm_addr_q + c_addr_one;
        end
        if (fire) begin
            word_count_d = word_count_q + c_addr_one;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase

        // Entry that will sit at the FIFO head next cycle; when the FIFO is
        // (or becomes) empty, only the word being pushed now can be there.
        head_ptr   = rd_ptr_d;
        stay_empty = (count_q == '0) || ((count_q == c_cnt_one) && pop);

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_n      = ST_RUN;
                    cm_addr_d    = base_addr;
                    limit_d      = code_limit;
                    rd_ptr_d     = '0;
                    wr_ptr_d     = '0;
                    count_d      = '0;
                    word_count_d = '0;
                    error_d      = 1'b0;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_n = (count_d == '0) ? ST_TERM : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_n = ST_TERM;
                end
            end
            ST_TERM: begin
                if (fire) begin
                    state_n = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // A write is wanted next cycle whenever data is queued in RUN/DRAIN
        // or the terminator is pending; the address is checked against the
        // limit before the write is ever presented.
        if ((state_n == ST_RUN) || (state_n == ST_DRAIN)) begin
            want_write = (count_d != '0);
        end else begin
            want_write = (state_n == ST_TERM);
        end
        overrun = want_write && (cm_addr_d > limit_d);

        state_d = state_n;
        if (overrun) begin
            state_d  = ST_ERR;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            error_d  = 1'b1;
        end

        cm_we_d    = want_write && !overrun;
        cm_wdata_d = cm_wdata_q;
        if (cm_we_d) begin
            if (state_n == ST_TERM) begin
                cm_wdata_d = TERM_INST;
            end else if (stay_empty) begin
                cm_wdata_d = bus.arm_inst;
            end else begin
                cm_wdata_d = fifo_mem_q[head_ptr];
            end
        end

        inst_ready_d = (state_d == ST_RUN) && (count_d != c_depth);
        busy_d       = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_TERM);
    end

    // Control state and registered outputs, cleared asynchronously on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            limit_q      <= '0;
            cm_addr_q    <= '0;
            cm_wdata_q   <= '0;
            cm_we_q      <= 1'b0;
            inst_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            limit_q      <= limit_d;
            cm_addr_q    <= cm_addr_d;
            cm_wdata_q   <= cm_wdata_d;
            cm_we_q      <= cm_we_d;
            inst_ready_q <= inst_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
        end
    end

    // FIFO storage; contents are meaningless outside the occupied window
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= bus.arm_inst;
        end
    end

endmodule
`default_nettype wire
